// File: rtl/taxi_rr_arbiter_pkg.sv
// Shared helpers for the taxi round-robin arbiter slice.
package taxi_rr_arbiter_pkg;

    // Width of an index or counter that must hold at least n distinct values, never narrower than 1 bit.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/taxi_penc.sv
// Priority encoder: reports the highest-priority set bit as an index and as a one-hot mask.
module taxi_penc
    import taxi_rr_arbiter_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int LSB_HIGH_PRIO = 1
) (
    input  logic [WIDTH-1:0]                 input_unencoded_i,
    output logic                             output_valid_o,
    output logic [safe_clog2(WIDTH)-1:0]     output_encoded_o,
    output logic [WIDTH-1:0]                 output_mask_o
);

    localparam int unsigned IW = safe_clog2(WIDTH);

    // Scan from lowest to highest priority so the last hit seen is the winner.
    always_comb begin
        output_valid_o   = |input_unencoded_i;
        output_encoded_o = '0;
        output_mask_o    = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            int unsigned idx;
            idx = (LSB_HIGH_PRIO != 0) ? (WIDTH - 1 - k) : k;
            if (input_unencoded_i[idx]) begin
                output_encoded_o   = IW'(idx);
                output_mask_o      = '0;
                output_mask_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/taxi_rr_arbiter.sv
// Registered fixed-priority / round-robin arbiter with optional grant hold, ack release and hold limit.
module taxi_rr_arbiter
    import taxi_rr_arbiter_pkg::*;
#(
    parameter int PORTS             = 4,
    parameter int ARB_ROUND_ROBIN   = 1,
    parameter int ARB_LSB_HIGH_PRIO = 1,
    parameter int ARB_BLOCK         = 1,
    parameter int ARB_BLOCK_ACK     = 1,
    parameter int MAX_HOLD          = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS-1:0]              req,
    input  logic [PORTS-1:0]              ack,
    output logic [PORTS-1:0]              grant,
    output logic                          grant_valid,
    output logic [safe_clog2(PORTS)-1:0]  grant_index,
    output logic                          hold_timeout
);

    localparam int unsigned IW = safe_clog2(PORTS);
    localparam int unsigned CW = safe_clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t            state_q, state_d;
    logic [PORTS-1:0]  grant_q, grant_d;
    logic [IW-1:0]     index_q, index_d;
    logic [PORTS-1:0]  rr_mask_q, rr_mask_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              m_valid, u_valid, win_valid;
    logic [IW-1:0]     m_idx, u_idx, win_idx;
    logic [PORTS-1:0]  m_mask, u_mask, win_mask;
    logic              rel_hold, timeout_c, release_c, arbitrate;

    taxi_penc #(.WIDTH(PORTS), .LSB_HIGH_PRIO(ARB_LSB_HIGH_PRIO)) u_penc_masked (
        .input_unencoded_i (req & rr_mask_q),
        .output_valid_o    (m_valid),
        .output_encoded_o  (m_idx),
        .output_mask_o     (m_mask)
    );

    taxi_penc #(.WIDTH(PORTS), .LSB_HIGH_PRIO(ARB_LSB_HIGH_PRIO)) u_penc_unmasked (
        .input_unencoded_i (req),
        .output_valid_o    (u_valid),
        .output_encoded_o  (u_idx),
        .output_mask_o     (u_mask)
    );

    // Winner selection and release decision for the current cycle.
    always_comb begin
        win_valid = m_valid | u_valid;
        win_idx   = m_valid ? m_idx  : u_idx;
        win_mask  = m_valid ? m_mask : u_mask;
        if (ARB_BLOCK == 0) begin
            rel_hold = 1'b1;
        end else if (ARB_BLOCK_ACK != 0) begin
            rel_hold = ack[index_q];
        end else begin
            rel_hold = !req[index_q];
        end
        timeout_c = (MAX_HOLD > 0) && (cnt_q == CW'(MAX_HOLD - 1));
        release_c = (state_q == GRANTED) && (rel_hold || timeout_c);
        arbitrate = (state_q == IDLE) || release_c;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_valid) state_d = GRANTED;
            GRANTED: if (release_c && !win_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant, mask and hold-counter next values.
    always_comb begin
        grant_d   = grant_q;
        index_d   = index_q;
        rr_mask_d = rr_mask_q;
        cnt_d     = cnt_q;
        if (arbitrate) begin
            cnt_d = '0;
            if (win_valid) begin
                grant_d = win_mask;
                index_d = win_idx;
                if (ARB_ROUND_ROBIN != 0) begin
                    for (int unsigned j = 0; j < PORTS; j++) begin
                        rr_mask_d[j] = (ARB_LSB_HIGH_PRIO != 0) ? (j > 32'(win_idx)) : (j < 32'(win_idx));
                    end
                end
            end else begin
                grant_d = '0;
                index_d = '0;
            end
        end else if ((state_q == GRANTED) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q   <= '0;
            index_q   <= '0;
            rr_mask_q <= '1;
            cnt_q     <= '0;
        end else begin
            grant_q   <= grant_d;
            index_q   <= index_d;
            rr_mask_q <= rr_mask_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs.
    always_comb begin
        grant        = grant_q;
        grant_index  = index_q;
        grant_valid  = (state_q == GRANTED);
        hold_timeout = (state_q == GRANTED) && timeout_c;
    end

endmodule
